// File: rtl/hht_spmv_row_accumulator.sv
// rtl/hht_spmv_row_accumulator.sv - SpMV row multiply-accumulate with per-row result FIFO.
// Optional: define HHT_ACC_SAT_EN for unsigned saturating product/sum instead of modulo wrap.
module hht_spmv_row_accumulator #(
    parameter int DATA_W     = 32,
    parameter int ACC_W      = 32,
    parameter int ROW_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ROW_W-1:0]  num_rows_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_mval_i,
    input  logic [DATA_W-1:0] in_vval_i,
    input  logic              in_last_i,
    input  logic              in_empty_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ROW_W-1:0]  out_row_o,
    output logic [ACC_W-1:0]  out_sum_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_e;

    state_e                   state_q, state_d;
    logic [ROW_W-1:0]         num_rows_q;
    logic [ROW_W-1:0]         row_cnt_q, row_cnt_d;
    logic [ACC_W-1:0]         acc_q;
    logic                     p1_valid_q, p1_last_q;
    logic [ACC_W-1:0]         p1_prod_q;
    logic [ROW_W+ACC_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]         count_q;

    logic                     beat_xfer, in_flight, final_pending, push, pop;
    logic [ROW_W-1:0]         row_cnt_inc;
    logic [CNT_W:0]           occupancy;
    logic [ACC_W-1:0]         prod_in, acc_next;
    logic [ACC_W:0]           sum_w;

`ifdef HHT_ACC_SAT_EN
    logic                     p1_sat_q, sat_q, prod_ovf, sat_any;
    logic [2*DATA_W-1:0]      full_prod;

    assign full_prod = (2*DATA_W)'(in_mval_i) * (2*DATA_W)'(in_vval_i);
    assign prod_ovf  = |(full_prod >> ACC_W);
    assign prod_in   = in_empty_i ? '0 : (prod_ovf ? '1 : full_prod[ACC_W-1:0]);
    assign sum_w     = {1'b0, acc_q} + {1'b0, p1_prod_q};
    assign sat_any   = sat_q | p1_sat_q | sum_w[ACC_W];
    assign acc_next  = sat_any ? '1 : sum_w[ACC_W-1:0];
`else
    // Operands widened to ACC_W first: the low ACC_W product bits only depend on them.
    assign prod_in  = in_empty_i ? '0 : ACC_W'(ACC_W'(in_mval_i) * ACC_W'(in_vval_i));
    assign sum_w    = {1'b0, acc_q} + {1'b0, p1_prod_q};
    assign acc_next = sum_w[ACC_W-1:0];
`endif

    assign row_cnt_inc   = row_cnt_q + ROW_W'(1);
    assign in_flight     = p1_valid_q & p1_last_q;
    // Stop accepting once the final row's last beat is already in the pipeline.
    assign final_pending = in_flight && (row_cnt_inc == num_rows_q);
    assign occupancy     = {1'b0, count_q} + {{CNT_W{1'b0}}, in_flight};
    assign in_ready_o    = (state_q == S_ACCUM) && !final_pending
                           && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign beat_xfer     = in_valid_i & in_ready_o;
    assign push          = in_flight;
    assign pop           = out_ready_i && (count_q != '0);

    assign out_valid_o = (count_q != '0);
    assign out_row_o   = out_valid_o ? mem_q[rd_ptr_q][ROW_W+ACC_W-1:ACC_W] : '0;
    assign out_sum_o   = out_valid_o ? mem_q[rd_ptr_q][ACC_W-1:0] : '0;

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        done_o    = 1'b0;
        busy_o    = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    row_cnt_d = '0;
                    state_d   = (num_rows_i == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (push) begin
                    row_cnt_d = row_cnt_inc;
                    if (row_cnt_inc == num_rows_q) state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            num_rows_q <= '0;
            row_cnt_q  <= '0;
            acc_q      <= '0;
            p1_valid_q <= 1'b0;
            p1_last_q  <= 1'b0;
            p1_prod_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef HHT_ACC_SAT_EN
            p1_sat_q   <= 1'b0;
            sat_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            if (state_q == S_IDLE && start_i) num_rows_q <= num_rows_i;
            p1_valid_q <= beat_xfer;
            if (beat_xfer) begin
                p1_prod_q <= prod_in;
                p1_last_q <= in_last_i | in_empty_i;
`ifdef HHT_ACC_SAT_EN
                p1_sat_q  <= prod_ovf & ~in_empty_i;
`endif
            end
            if (p1_valid_q) begin
                acc_q <= push ? '0 : acc_next;
`ifdef HHT_ACC_SAT_EN
                sat_q <= push ? 1'b0 : sat_any;
`endif
            end
            if (push) begin
                mem_q[wr_ptr_q] <= {row_cnt_q, acc_next};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_hht_spmv_row_accumulator.sv
// tb/tb_hht_spmv_row_accumulator.sv - self-checking bench for hht_spmv_row_accumulator.
module tb_hht_spmv_row_accumulator;
    localparam logic [63:0] MAX32 = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_rows = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_mval = '0;
    logic [31:0] in_vval = '0;
    logic        in_last = 1'b0;
    logic        in_empty = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_row;
    logic [31:0] out_sum;
    logic        busy;
    logic        done;

    hht_spmv_row_accumulator dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_rows_i(num_rows),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_mval_i(in_mval),
        .in_vval_i(in_vval), .in_last_i(in_last), .in_empty_i(in_empty),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_row_o(out_row),
        .out_sum_o(out_sum), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] m0, v0, m1, v1;
        logic [31:0] exp_sum;
    } vec_t;

    logic [47:0] got_q[$];
    logic [47:0] exp_q[$];
    int          cmp_idx = 0;
    int          done_cnt = 0;
    int          beats_acc = 0;
    int          total = 0;
    int          passed = 0;
    bit          rnd_bp = 1'b0;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back({out_row, out_sum});
        if (done) done_cnt++;
        if (in_valid && in_ready) beats_acc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    task automatic fail_timeout(input string name);
        total++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_add(input logic [31:0] acc, input logic [31:0] m,
                                              input logic [31:0] v);
        logic [63:0] p;
        logic [63:0] s;
        p = {32'h0, m} * {32'h0, v};
`ifdef HHT_ACC_SAT_EN
        if (p > MAX32) p = MAX32;
        s = {32'h0, acc} + p;
        if (s > MAX32) s = MAX32;
`else
        s = ({32'h0, acc} + p) & MAX32;
`endif
        return s[31:0];
    endfunction

    task automatic start_mat(input logic [15:0] n);
        start = 1'b1;
        num_rows = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] m, input logic [31:0] v, input logic last,
                             input logic empty);
        bit ok = 1'b0;
        in_mval = m;
        in_vval = v;
        in_last = last;
        in_empty = empty;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            ok = in_ready;
            tick();
            if (ok) break;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        in_empty = 1'b0;
        if (!ok) fail_timeout("beat_accept");
    endtask

    task automatic expect_row(input logic [15:0] r, input logic [31:0] s);
        exp_q.push_back({r, s});
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        tick();
        if (!seen) fail_timeout("done_pulse");
        else begin
            @(negedge clk);
            chk("busy_after_done", busy, 0);
            chk("done_one_cycle", done, 0);
            tick();
        end
    endtask

    task automatic check_results();
        for (int i = 0; i < 500 && got_q.size() < exp_q.size(); i++) tick();
        chk("result_count", got_q.size(), exp_q.size());
        for (int i = cmp_idx; i < exp_q.size() && i < got_q.size(); i++) begin
            chk("out_row", got_q[i][47:32], exp_q[i][47:32]);
            chk("out_sum", got_q[i][31:0], exp_q[i][31:0]);
        end
        cmp_idx = exp_q.size();
    endtask

    initial begin
        vec_t        tbl[6];
        int          base_done, base_beats, n, k;
        logic [31:0] m, v, s;

        tbl[0] = '{32'd3, 32'd4, 32'd5, 32'd6, 32'd42};
        tbl[1] = '{32'hFFFF_FFFF, 32'd2, 32'd1, 32'd1, 32'hFFFF_FFFF};
`ifdef HHT_ACC_SAT_EN
        tbl[2] = '{32'h8000_0000, 32'd2, 32'd1, 32'd1, 32'hFFFF_FFFF};
        tbl[5] = '{32'h0001_0000, 32'h0001_0000, 32'd5, 32'd1, 32'hFFFF_FFFF};
`else
        tbl[2] = '{32'h8000_0000, 32'd2, 32'd1, 32'd1, 32'h0000_0001};
        tbl[5] = '{32'h0001_0000, 32'h0001_0000, 32'd5, 32'd1, 32'd5};
`endif
        tbl[3] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        tbl[4] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'd1, 32'd0, 32'hFFFE_0001};

        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // two rows, free-flowing output
        out_ready = 1'b1;
        base_done = done_cnt;
        start_mat(16'd2);
        send_beat(32'd3, 32'd4, 1'b0, 1'b0);
        send_beat(32'd5, 32'd6, 1'b1, 1'b0);
        send_beat(32'd8, 32'd45, 1'b1, 1'b0);
        expect_row(16'd0, 32'd42);
        expect_row(16'd1, 32'd360);
        wait_done();
        check_results();
        chk("done_pulses_once", done_cnt - base_done, 1);

        // empty middle row
        start_mat(16'd3);
        base_beats = beats_acc;
        send_beat(32'd7, 32'd9, 1'b1, 1'b0);
        send_beat(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1);
        send_beat(32'd10, 32'd10, 1'b0, 1'b0);
        send_beat(32'd2, 32'd2, 1'b1, 1'b0);
        expect_row(16'd0, 32'd63);
        expect_row(16'd1, 32'd0);
        expect_row(16'd2, 32'd104);
        wait_done();
        check_results();
        chk("beats_accepted", beats_acc - base_beats, 4);

        for (int i = 0; i < 6; i++) begin
            start_mat(16'd1);
            send_beat(tbl[i].m0, tbl[i].v0, 1'b0, 1'b0);
            send_beat(tbl[i].m1, tbl[i].v1, 1'b1, 1'b0);
            expect_row(16'd0, tbl[i].exp_sum);
            wait_done();
            check_results();
        end

        // output back-pressure with six single-beat rows
        out_ready = 1'b0;
        start_mat(16'd6);
        for (int r = 0; r < 4; r++) begin
            send_beat(32'(r + 1), 32'd10, 1'b1, 1'b0);
            expect_row(16'(r), 32'((r + 1) * 10));
        end
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        repeat (5) tick();
        @(negedge clk);
        chk("bp_in_ready_held", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_head_row", out_row, 0);
        chk("bp_head_sum", out_sum, 10);
        tick();
        out_ready = 1'b1;
        for (int r = 4; r < 6; r++) begin
            send_beat(32'(r + 1), 32'd10, 1'b1, 1'b0);
            expect_row(16'(r), 32'((r + 1) * 10));
        end
        wait_done();
        check_results();

        // zero-row matrix
        start_mat(16'd0);
        @(negedge clk);
        chk("zero_rows_done", done, 1);
        chk("zero_rows_no_push", out_valid, 0);
        tick();
        @(negedge clk);
        chk("zero_rows_done_fall", done, 0);
        chk("zero_rows_idle", busy, 0);
        tick();
        check_results();

        // reset mid-row discards FIFO and partial sum
        out_ready = 1'b0;
        start_mat(16'd2);
        send_beat(32'd4, 32'd5, 1'b1, 1'b0);
        expect_row(16'd0, 32'd20);
        send_beat(32'd1, 32'd1, 1'b0, 1'b0);
        send_beat(32'd2, 32'd2, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_reset_out_valid", out_valid, 1);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_row", out_row, 0);
        chk("mid_rst_out_sum", out_sum, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        tick();
        rst_n = 1'b1;
        while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
        cmp_idx = exp_q.size();
        tick();
        start_mat(16'd1);
        send_beat(32'd2, 32'd3, 1'b1, 1'b0);
        expect_row(16'd0, 32'd6);
        @(negedge clk);
        chk("latency_n1_empty", out_valid, 0);
        @(negedge clk);
        chk("latency_n2_valid", out_valid, 1);
        chk("latency_n2_done", done, 1);
        chk("latency_n2_row", out_row, 0);
        chk("latency_n2_sum", out_sum, 6);
        tick();
        out_ready = 1'b1;
        check_results();

        // randomized matrices against the arithmetic model
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 5);
            rnd_bp = 1'b1;
            start_mat(16'(n));
            for (int r = 0; r < n; r++) begin
                k = $urandom_range(0, 3);
                s = '0;
                if (k == 0) send_beat($urandom, $urandom, 1'b0, 1'b1);
                for (int j = 0; j < k; j++) begin
                    case ($urandom_range(0, 3))
                        0: m = 32'($urandom_range(0, 15));
                        1: m = $urandom;
                        2: m = 32'hFFFF_FFFF;
                        default: m = 32'h1 << $urandom_range(0, 31);
                    endcase
                    v = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
                    s = model_add(s, m, v);
                    send_beat(m, v, (j == k - 1), 1'b0);
                end
                expect_row(16'(r), s);
            end
            rnd_bp = 1'b0;
            out_ready = 1'b1;
            wait_done();
            check_results();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hht_spmv_row_accumulator.md
Name: hht_spmv_row_accumulator

Overview:
- Downstream of the CSR fetch `control` stage in the HHT sparse matrix-vector path.
- Consumes the stream of (matrix value, gathered vector value) pairs that `control` reads through its addr2 port, tagged with end-of-row and empty-row markers.
- Multiplies each pair and accumulates per row.
- Pushes one (row index, row sum) result per CSR row into a small output FIFO for the write-back stage.

Parameters:
- DATA_W, 32, width of matrix and vector operands (unsigned).
- ACC_W, 32, width of the accumulator and row sum.
- ROW_W, 16, width of the row index and row count.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
- Clk  in  1  clock, all state on rising edge.
- Rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches num_rows and begins a matrix.
- num_rows  in  ROW_W  number of CSR rows in this matrix.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_mval  in  DATA_W  matrix nonzero value.
- in_vval  in  DATA_W  vector element for that nonzero's column.
- in_last  in  1  beat is the last nonzero of the current row.
- in_empty  in  1  row has no nonzeros; beat carries no product (mval/vval ignored); implies last.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head this cycle.
- out_row  out  ROW_W  row index of the head result.
- out_sum  out  ACC_W  row sum of the head result.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the last row's result enters the FIFO.

Behaviour:
- Reset (Rst=0, async) values: in_ready=0, out_valid=0, out_row=0, out_sum=0, busy=0, done=0. FIFO empty, accumulator 0, row counter 0, pipeline invalid, state IDLE.
- States:
  - IDLE: in_ready=0. start moves to ACCUM, latches num_rows and clears row_cnt. If start arrives with num_rows=0, go straight to DONE.
  - ACCUM: in_ready = (fifo_count + rows_in_flight < FIFO_DEPTH). A beat transfers when in_valid and in_ready are both 1.
  - DONE: pulse done for 1 cycle, then return to IDLE. start in the DONE cycle is ignored.
- Pipeline stage 1 (P1): register product = in_mval*in_vval truncated to ACC_W LSBs, plus the last and empty flags. For an empty beat, product is forced to 0.
- Pipeline stage 2 (P2): acc_next = acc + product.
  - Wraps modulo 2^ACC_W, except when the saturation feature (see Optional Feature) is enabled.
  - On a last beat: push {row_cnt, acc_next} into the FIFO, clear acc to 0, increment row_cnt.
  - Otherwise acc <= acc_next.
- Latency: a last beat accepted in cycle N is in the FIFO at the end of N+2. out_valid is asserted in N+2 if the FIFO was empty. rows_in_flight counts last beats in P1/P2 so the FIFO never overflows.
- When the push makes row_cnt reach num_rows, go to DONE. Later in_valid beats are not accepted (in_ready=0).
- FIFO: first-fall-through. out_row/out_sum show the head while out_valid=1 and hold stable until out_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - A full FIFO holds in_ready low; no beat is ever dropped.
  - Pop while empty has no effect.
- Beats with in_valid=0 do not advance the pipeline or touch acc.
- start in ACCUM is ignored.
- An async reset mid-row discards the partial accumulator, pipeline contents and FIFO contents.

Optional Feature:
- Macro: HHT_ACC_SAT_EN.
- Defined: product and sum saturate to 2^ACC_W-1 (unsigned) when the full product or sum exceeds ACC_W bits. A saturated row's result carries out_sum=all-ones. The sticky saturation flag clears at each row start.
- Undefined: plain modulo-2^ACC_W wrap, no saturation logic.

Test Plan:
- start, num_rows=2. Row 0 beats (3,4),(5,6,last); row 1 beats (8,45,last); out_ready=1 -> out (0,42) then (1,360); done pulses once; busy falls the next cycle.
- num_rows=3, middle row in_empty=1 -> results (0,x),(1,0),(2,y) in order; empty row costs exactly one beat.
- out_ready=0, num_rows=6, each row a single last beat -> in_ready drops once 4 results are queued or in flight; no loss. Release out_ready -> all 6 rows drain in order.
- Beats (0xFFFF_FFFF,2),(1,1,last) -> out_sum 0xFFFF_FFFE+1 = 0xFFFF_FFFF. Beats (0x8000_0000,2),(1,1,last) -> 0x0000_0001 when the macro is undefined, 0xFFFF_FFFF when HHT_ACC_SAT_EN is defined.
- Rst low for 1 cycle after 2 beats of a row -> all outputs return to reset values. A new start, num_rows=1, beat (2,3,last) -> out (0,6).
- start with num_rows=0 -> done pulses 1 cycle after start; no FIFO push.
